// File: rtl/spectro_capture_multi.sv
// spectro_capture_multi
// Multi-channel spectrogram capture path. Channel samples are summed into
// saturating per-channel energy accumulators. Each rising RTC edge stores the
// accumulators as one time bin. After N_BINS bins the frame is held until the
// external readout clock streams it out over N_LANES serial lanes.
//
// Ports
//   clk                     acquisition clock; all state is on its rising edge
//   rst_n                   asynchronous active-low reset
//   ch                      packed channel samples, ch0 in the LSBs
//   sample_valid            ch is valid this cycle
//   rtc_in                  raw RTC level, asynchronous to clk
//   rd_clk_in               raw readout clock level, asynchronous to clk
//   serial_out              readout lanes, held between readout ticks
//   sl_time                 1-cycle pulse on each bin store
//   sl_ch                   1-cycle pulse when a group carrying a word's first bit is emitted
//   signal_detected         high from detection until readout ends
//   memorization_completed  high in DONE and SEND
//   sending_data            high in SEND
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for a sample at or above DET_THRESH
// CAPTURE | accumulating; each rtc tick stores one bin
// DONE    | frame complete, waiting for the first readout tick
// SEND    | one lane group per readout tick, then one terminating tick
module spectro_capture_multi #(
   parameter int N_CH       = 2,
   parameter int SAMPLE_W   = 7,
   parameter int ACC_W      = 12,
   parameter int N_BINS     = 4,
   parameter int N_LANES    = 2,
   parameter int DET_THRESH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_CH*SAMPLE_W-1:0] ch,
   input  logic                     sample_valid,
   input  logic                     rtc_in,
   input  logic                     rd_clk_in,
   output logic [N_LANES-1:0]       serial_out,
   output logic                     sl_time,
   output logic                     sl_ch,
   output logic                     signal_detected,
   output logic                     memorization_completed,
   output logic                     sending_data
);

   localparam int ROW_W    = N_CH * ACC_W;
   localparam int FRAME_W  = N_BINS * ROW_W;
   localparam int N_GROUPS = FRAME_W / N_LANES;
   localparam int BIN_W    = (N_BINS > 1) ? $clog2(N_BINS) : 1;
   localparam int GRP_W    = $clog2(N_GROUPS + 1);
   localparam int POS_W    = (ACC_W > 1) ? $clog2(ACC_W) : 1;

   if (FRAME_W % N_LANES != 0) begin : g_bad_lanes
      $error("spectro_capture_multi: frame width must be divisible by N_LANES");
   end
   if (ACC_W <= SAMPLE_W) begin : g_bad_acc
      $error("spectro_capture_multi: ACC_W must exceed SAMPLE_W");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_CAPTURE,
      S_DONE,
      S_SEND
   } state_t;

   state_t state_q, state_d;

   logic rtc_s1, rtc_s2, rtc_d, rise_tick;
   logic rd_s1, rd_s2, rd_d, rd_tick;

   logic [SAMPLE_W-1:0] ch_arr [N_CH];
   logic [ACC_W-1:0]    acc_q  [N_CH];
   logic [ROW_W-1:0]    acc_row;
   logic [FRAME_W-1:0]  frame_q, frame_shift, frame_rot;
   logic [BIN_W-1:0]    bin_q;
   logic [GRP_W-1:0]    grp_q;
   logic [POS_W-1:0]    pos_q;
   logic                detect, last_bin, store, emit, finish, word_start;

   // 2-flop synchronizers, edge register and registered rising-edge tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rtc_s1    <= 1'b0;
         rtc_s2    <= 1'b0;
         rtc_d     <= 1'b0;
         rise_tick <= 1'b0;
         rd_s1     <= 1'b0;
         rd_s2     <= 1'b0;
         rd_d      <= 1'b0;
         rd_tick   <= 1'b0;
      end else begin
         rtc_s1    <= rtc_in;
         rtc_s2    <= rtc_s1;
         rtc_d     <= rtc_s2;
         rise_tick <= rtc_s2 & ~rtc_d;
         rd_s1     <= rd_clk_in;
         rd_s2     <= rd_s1;
         rd_d      <= rd_s2;
         rd_tick   <= rd_s2 & ~rd_d;
      end
   end

   function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                input logic [SAMPLE_W-1:0] s);
      logic [ACC_W:0] sum;
      sum = {1'b0, a} + (ACC_W+1)'(s);
      return sum[ACC_W] ? '1 : sum[ACC_W-1:0];
   endfunction

   always_comb begin
      detect = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         ch_arr[i] = ch[i*SAMPLE_W +: SAMPLE_W];
         if (sample_valid && (int'(ch_arr[i]) >= DET_THRESH))
            detect = 1'b1;
      end
   end

   // ch0 lands in the most significant word of a row so that the frame,
   // shifted in bin by bin, ends up in stream order from the MSB down.
   always_comb begin
      acc_row = '0;
      for (int i = 0; i < N_CH; i++)
         acc_row[ROW_W-1-i*ACC_W -: ACC_W] = acc_q[i];
   end

   assign frame_shift = FRAME_W'({frame_q, acc_row});
   // Rotating instead of shifting leaves the frame intact after a full readout.
   assign frame_rot   = (frame_q << N_LANES) | (frame_q >> (FRAME_W - N_LANES));
   assign last_bin    = (bin_q == BIN_W'(N_BINS - 1));
   assign word_start  = (pos_q == '0) || (int'(pos_q) + N_LANES > ACC_W);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      store   = 1'b0;
      emit    = 1'b0;
      finish  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (detect) state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            if (rise_tick) begin
               store = 1'b1;
               if (last_bin) state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (rd_tick) begin
               emit    = 1'b1;
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            if (rd_tick) begin
               if (grp_q == '0) begin
                  finish  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  emit = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CH; i++) acc_q[i] <= '0;
         frame_q                <= '0;
         bin_q                  <= '0;
         grp_q                  <= '0;
         pos_q                  <= '0;
         serial_out             <= '0;
         sl_time                <= 1'b0;
         sl_ch                  <= 1'b0;
         signal_detected        <= 1'b0;
         memorization_completed <= 1'b0;
         sending_data           <= 1'b0;
      end else begin
         sl_time <= store;
         sl_ch   <= emit & word_start;

         if (state_q == S_IDLE) begin
            for (int i = 0; i < N_CH; i++)
               acc_q[i] <= detect ? ACC_W'(ch_arr[i]) : '0;
            if (detect) begin
               bin_q           <= '0;
               signal_detected <= 1'b1;
            end
         end

         if (state_q == S_CAPTURE) begin
            if (store) begin
               frame_q <= frame_shift;
               bin_q   <= last_bin ? '0 : bin_q + BIN_W'(1);
               // A sample coinciding with the tick opens the next bin.
               for (int i = 0; i < N_CH; i++)
                  acc_q[i] <= (sample_valid && !last_bin) ? ACC_W'(ch_arr[i]) : '0;
               if (last_bin) memorization_completed <= 1'b1;
            end else if (sample_valid) begin
               for (int i = 0; i < N_CH; i++)
                  acc_q[i] <= sat_add(acc_q[i], ch_arr[i]);
            end
         end

         if (emit) begin
            for (int l = 0; l < N_LANES; l++)
               serial_out[l] <= frame_q[FRAME_W-1-l];
            frame_q      <= frame_rot;
            pos_q        <= POS_W'((int'(pos_q) + N_LANES) % ACC_W);
            grp_q        <= (state_q == S_DONE) ? GRP_W'(N_GROUPS - 1) : grp_q - GRP_W'(1);
            sending_data <= 1'b1;
         end

         if (finish) begin
            serial_out             <= '0;
            pos_q                  <= '0;
            signal_detected        <= 1'b0;
            memorization_completed <= 1'b0;
            sending_data           <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_spectro_capture_multi.sv
module tb_spectro_capture_multi;

   localparam int ACC_W   = 12;
   localparam int N_LANES = 2;
   localparam int N_WORDS = 8;
   localparam int N_EMIT  = 48;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [13:0] ch = '0;
   logic        sample_valid = 1'b0;
   logic        rtc_in = 1'b0;
   logic        rd_clk_in = 1'b0;
   logic [1:0]  serial_out;
   logic        sl_time, sl_ch, signal_detected, memorization_completed, sending_data;

   spectro_capture_multi dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .ch                     (ch),
      .sample_valid           (sample_valid),
      .rtc_in                 (rtc_in),
      .rd_clk_in              (rd_clk_in),
      .serial_out             (serial_out),
      .sl_time                (sl_time),
      .sl_ch                  (sl_ch),
      .signal_detected        (signal_detected),
      .memorization_completed (memorization_completed),
      .sending_data           (sending_data)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] so;
      logic       slch;
      logic       sd;
      logic       mc;
      logic       sig;
   } rd_exp_t;

   typedef struct packed {
      logic slt;
      logic mc;
      logic sig;
   } rtc_exp_t;

   int        n_chk = 0;
   int        n_fail = 0;
   int        slt_cnt = 0;
   int        slch_cnt = 0;
   rd_exp_t   rd_q [$];
   rtc_exp_t  rtc_q [$];
   logic [4:0] rd_hist, rtc_hist;
   logic [11:0] frame_exp [N_WORDS];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected tick timing: an input rising before edge k is acted on at edge k+3.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_hist  <= '0;
         rtc_hist <= '0;
      end else begin
         rd_hist  <= {rd_hist[3:0], rd_clk_in};
         rtc_hist <= {rtc_hist[3:0], rtc_in};
      end
   end

   always @(negedge clk) begin : monitor
      rd_exp_t  re;
      rtc_exp_t te;
      if (sl_time) slt_cnt++;
      if (sl_ch)   slch_cnt++;
      if (rst_n && rd_hist[4:3] == 2'b01) begin
         if (rd_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL rd_unexpected: got readout event expected none at %0t", $time);
         end else begin
            re = rd_q.pop_front();
            chk("serial_out", 32'(serial_out), 32'(re.so));
            chk("sl_ch", 32'(sl_ch), 32'(re.slch));
            chk("sending_data", 32'(sending_data), 32'(re.sd));
            chk("rd_flags", 32'({memorization_completed, signal_detected}),
                32'({re.mc, re.sig}));
         end
      end
      if (rst_n && rtc_hist[4:3] == 2'b01) begin
         if (rtc_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL rtc_unexpected: got rtc event expected none at %0t", $time);
         end else begin
            te = rtc_q.pop_front();
            chk("sl_time", 32'(sl_time), 32'(te.slt));
            chk("rtc_flags", 32'({memorization_completed, signal_detected}),
                32'({te.mc, te.sig}));
         end
      end
   end

   task automatic samp(input logic [6:0] c0, input logic [6:0] c1, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         ch           = {c1, c0};
         sample_valid = 1'b1;
      end
      @(negedge clk);
      sample_valid = 1'b0;
   endtask

   task automatic rtc_pulse(input bit wv, input logic [6:0] c0, input logic [6:0] c1,
                            input rtc_exp_t e);
      @(negedge clk);
      rtc_in = 1'b1;
      rtc_q.push_back(e);
      repeat (3) @(negedge clk);
      if (wv) begin
         ch           = {c1, c0};
         sample_valid = 1'b1;
      end
      @(negedge clk);
      sample_valid = 1'b0;
      rtc_in       = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic rd_pulse(input rd_exp_t e);
      @(negedge clk);
      rd_clk_in = 1'b1;
      rd_q.push_back(e);
      repeat (4) @(negedge clk);
      rd_clk_in = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   function automatic logic sbit(input int g);
      logic [11:0] w;
      w = frame_exp[g / ACC_W];
      return w[ACC_W-1 - (g % ACC_W)];
   endfunction

   task automatic read_groups(input int n);
      rd_exp_t e;
      for (int t = 0; t < n; t++) begin
         e.so[0] = sbit(N_LANES*t);
         e.so[1] = sbit(N_LANES*t + 1);
         e.slch  = ((N_LANES*t) % ACC_W == 0) || ((N_LANES*t + 1) % ACC_W == 0);
         e.sd    = 1'b1;
         e.mc    = 1'b1;
         e.sig   = 1'b1;
         rd_pulse(e);
      end
   endtask

   function automatic logic [6:0] all_outs();
      return {serial_out, sl_time, sl_ch, signal_detected, memorization_completed, sending_data};
   endfunction

   initial begin
      // Reset with random activity on every input.
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         ch           = 14'($urandom);
         sample_valid = 1'($urandom);
         rtc_in       = 1'($urandom);
         rd_clk_in    = 1'($urandom);
         #1 chk("reset_outputs", 32'(all_outs()), 32'h0);
      end
      @(negedge clk);
      ch = '0; sample_valid = 1'b0; rtc_in = 1'b0; rd_clk_in = 1'b0;
      repeat (6) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("after_release", 32'(all_outs()), 32'h0);

      // Ticks in IDLE are ignored.
      rd_pulse('0);
      rtc_pulse(1'b0, 7'd0, 7'd0, '0);

      // Frame 1.
      samp(7'd15, 7'd15, 1);
      chk("below_thresh", 32'(signal_detected), 32'h0);
      samp(7'd16, 7'd2, 1);
      chk("detect", 32'(signal_detected), 32'h1);
      samp(7'd5, 7'd3, 9);
      rtc_pulse(1'b1, 7'd7, 7'd1, '{slt: 1'b1, mc: 1'b0, sig: 1'b1});
      samp(7'd7, 7'd1, 2);
      rtc_pulse(1'b0, 7'd0, 7'd0, '{slt: 1'b1, mc: 1'b0, sig: 1'b1});
      samp(7'd127, 7'd0, 40);
      rtc_pulse(1'b0, 7'd0, 7'd0, '{slt: 1'b1, mc: 1'b0, sig: 1'b1});
      samp(7'd1, 7'd100, 3);
      rtc_pulse(1'b0, 7'd0, 7'd0, '{slt: 1'b1, mc: 1'b1, sig: 1'b1});
      chk("done_mc", 32'(memorization_completed), 32'h1);
      chk("done_not_sending", 32'(sending_data), 32'h0);
      samp(7'd50, 7'd50, 2);
      rtc_pulse(1'b0, 7'd0, 7'd0, '{slt: 1'b0, mc: 1'b1, sig: 1'b1});
      frame_exp = '{12'd61, 12'd29, 12'd21, 12'd3, 12'd4095, 12'd0, 12'd3, 12'd300};
      read_groups(N_EMIT);
      rd_pulse('0);

      // Frame 2, aborted by reset during readout.
      samp(7'd16, 7'd16, 1);
      rtc_pulse(1'b0, 7'd0, 7'd0, '{slt: 1'b1, mc: 1'b0, sig: 1'b1});
      rtc_pulse(1'b0, 7'd0, 7'd0, '{slt: 1'b1, mc: 1'b0, sig: 1'b1});
      rtc_pulse(1'b0, 7'd0, 7'd0, '{slt: 1'b1, mc: 1'b0, sig: 1'b1});
      rtc_pulse(1'b0, 7'd0, 7'd0, '{slt: 1'b1, mc: 1'b1, sig: 1'b1});
      frame_exp = '{12'd16, 12'd16, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0};
      read_groups(20);
      chk("mid_send", 32'(sending_data), 32'h1);
      rst_n = 1'b0;
      #1 chk("abort_outputs", 32'(all_outs()), 32'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Frame 3 restarts from bin 0.
      samp(7'd17, 7'd5, 1);
      chk("redetect", 32'(signal_detected), 32'h1);
      rtc_pulse(1'b0, 7'd0, 7'd0, '{slt: 1'b1, mc: 1'b0, sig: 1'b1});
      samp(7'd1, 7'd2, 2);
      rtc_pulse(1'b0, 7'd0, 7'd0, '{slt: 1'b1, mc: 1'b0, sig: 1'b1});
      samp(7'd9, 7'd9, 1);
      rtc_pulse(1'b0, 7'd0, 7'd0, '{slt: 1'b1, mc: 1'b0, sig: 1'b1});
      rtc_pulse(1'b0, 7'd0, 7'd0, '{slt: 1'b1, mc: 1'b1, sig: 1'b1});
      frame_exp = '{12'd17, 12'd5, 12'd2, 12'd4, 12'd9, 12'd9, 12'd0, 12'd0};
      read_groups(N_EMIT);
      rd_pulse('0);
      repeat (4) @(negedge clk);
      chk("end_idle", 32'(all_outs()), 32'h0);

      chk("rd_queue_empty", 32'(rd_q.size()), 32'h0);
      chk("rtc_queue_empty", 32'(rtc_q.size()), 32'h0);
      chk("sl_time_count", 32'(slt_cnt), 32'd12);
      chk("sl_ch_count", 32'(slch_cnt), 32'd20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
